// File: rtl/c_sel_pipe_adder_pkg.sv
// Shared definitions for the pipelined carry-select adder/subtractor.
package c_sel_pipe_adder_pkg;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_SUB = 1'b1
  } mode_e;

  function automatic int unsigned nseg(input int unsigned width, input int unsigned seg);
    return (seg == 0) ? 0 : width / seg;
  endfunction

  function automatic bit seg_legal(input int unsigned width, input int unsigned seg);
    return (seg != 0) && (width >= seg) && ((width % seg) == 0);
  endfunction

endpackage

// File: rtl/c_sel_pipe_adder_if.sv
// Operand/result bundle with valid/ready handshakes on both sides.
// master: producer of operands and consumer of results; slave: the adder.
interface c_sel_pipe_adder_if #(
  parameter int unsigned WIDTH = 24
) ();
  import c_sel_pipe_adder_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] S;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, A, B, cin, sub, out_ready,
    input  in_ready, out_valid, S, cout, ovf
  );

  modport slave (
    input  in_valid, A, B, cin, sub, out_ready,
    output in_ready, out_valid, S, cout, ovf
  );

endinterface

// File: rtl/c_sel_seg.sv
// One carry-select segment: both carry-in sums precomputed, then selected.
module c_sel_seg #(
  parameter int unsigned SEG = 8
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           ci,
  output logic [SEG-1:0] s,
  output logic           co
);

  logic [SEG:0] sum0;
  logic [SEG:0] sum1;

  always_comb begin
    sum0      = {1'b0, a} + {1'b0, b};
    sum1      = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, 1'b1};
    {co, s}   = ci ? sum1 : sum0;
  end

endmodule

// File: rtl/c_sel_pipe_adder.sv
// Pipelined carry-select adder/subtractor, one SEG-bit segment per stage.
// Ports: clk, rst (async, active-high), bus (slave side of c_sel_pipe_adder_if).
module c_sel_pipe_adder
  import c_sel_pipe_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned SEG   = 8
) (
  input  logic               clk,
  input  logic               rst,
  c_sel_pipe_adder_if.slave  bus
);

  localparam int unsigned NSEG = nseg(WIDTH, SEG);
  localparam int unsigned MSB  = WIDTH - 1;

  if (!seg_legal(WIDTH, SEG)) begin : g_bad_width
    $error("c_sel_pipe_adder: WIDTH (%0d) must be a nonzero multiple of SEG (%0d)", WIDTH, SEG);
  end

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             cy_eff;

  // Stage k registers: operands (skew), partial result (deskew), carry, valid, signs.
  logic [NSEG-1:0]  vld_q, vld_d, cy_q, cy_d, sa_q, sa_d, sb_q, sb_d;
  logic [WIDTH-1:0] a_q [NSEG];
  logic [WIDTH-1:0] a_d [NSEG];
  logic [WIDTH-1:0] b_q [NSEG];
  logic [WIDTH-1:0] b_d [NSEG];
  logic [WIDTH-1:0] s_q [NSEG];
  logic [WIDTH-1:0] s_d [NSEG];

  // What each stage sees on its input side this cycle.
  logic [NSEG-1:0]  src_vld, src_cy, src_sa, src_sb;
  logic [WIDTH-1:0] src_a [NSEG];
  logic [WIDTH-1:0] src_b [NSEG];
  logic [WIDTH-1:0] src_s [NSEG];

  logic [SEG-1:0]   seg_sum [NSEG];
  logic [NSEG-1:0]  seg_co;

  assign adv          = !vld_q[NSEG-1] || bus.out_ready;
  assign bus.in_ready = adv;

  always_comb begin
    b_eff  = (mode_e'(bus.sub) == MODE_SUB) ? ~bus.B : bus.B;
    cy_eff = (mode_e'(bus.sub) == MODE_SUB) ? ~bus.cin : bus.cin;
  end

  always_comb begin
    src_vld    = '0;
    src_cy     = '0;
    src_sa     = '0;
    src_sb     = '0;
    src_vld[0] = bus.in_valid;
    src_cy[0]  = cy_eff;
    src_sa[0]  = bus.A[MSB];
    src_sb[0]  = b_eff[MSB];
    src_a[0]   = bus.A;
    src_b[0]   = b_eff;
    src_s[0]   = '0;
    for (int unsigned k = 1; k < NSEG; k++) begin
      src_vld[k] = vld_q[k-1];
      src_cy[k]  = cy_q[k-1];
      src_sa[k]  = sa_q[k-1];
      src_sb[k]  = sb_q[k-1];
      src_a[k]   = a_q[k-1];
      src_b[k]   = b_q[k-1];
      src_s[k]   = s_q[k-1];
    end
  end

  for (genvar g = 0; g < NSEG; g++) begin : g_seg
    c_sel_seg #(.SEG(SEG)) u_seg (
      .a  (src_a[g][g*SEG +: SEG]),
      .b  (src_b[g][g*SEG +: SEG]),
      .ci (src_cy[g]),
      .s  (seg_sum[g]),
      .co (seg_co[g])
    );
  end

  // Single advance enable moves the whole pipe or freezes it; bubbles ride along.
  always_comb begin
    vld_d = vld_q;
    cy_d  = cy_q;
    sa_d  = sa_q;
    sb_d  = sb_q;
    for (int unsigned k = 0; k < NSEG; k++) begin
      a_d[k] = a_q[k];
      b_d[k] = b_q[k];
      s_d[k] = s_q[k];
    end
    if (adv) begin
      vld_d = src_vld;
      cy_d  = seg_co;
      sa_d  = src_sa;
      sb_d  = src_sb;
      for (int unsigned k = 0; k < NSEG; k++) begin
        a_d[k]                 = src_a[k];
        b_d[k]                 = src_b[k];
        s_d[k]                 = src_s[k];
        s_d[k][k*SEG +: SEG]   = seg_sum[k];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      cy_q  <= '0;
      sa_q  <= '0;
      sb_q  <= '0;
      for (int unsigned k = 0; k < NSEG; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      cy_q  <= cy_d;
      sa_q  <= sa_d;
      sb_q  <= sb_d;
      for (int unsigned k = 0; k < NSEG; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
      end
    end
  end

  assign bus.out_valid = vld_q[NSEG-1];
  assign bus.S         = s_q[NSEG-1];
  assign bus.cout      = cy_q[NSEG-1];
  assign bus.ovf       = (sa_q[NSEG-1] == sb_q[NSEG-1]) && (s_q[NSEG-1][MSB] != sa_q[NSEG-1]);

endmodule

// File: tb/tb_c_sel_pipe_adder.sv
// Scoreboard bench for c_sel_pipe_adder (main 24/8 instance plus 32/8 and 8/8).
module tb_c_sel_pipe_adder;

  localparam int unsigned NS = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  c_sel_pipe_adder_if #(.WIDTH(24)) bus ();
  c_sel_pipe_adder_if #(.WIDTH(32)) bus32 ();
  c_sel_pipe_adder_if #(.WIDTH(8))  bus8 ();

  c_sel_pipe_adder #(.WIDTH(24), .SEG(8)) dut   (.clk(clk), .rst(rst), .bus(bus));
  c_sel_pipe_adder #(.WIDTH(32), .SEG(8)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
  c_sel_pipe_adder #(.WIDTH(8),  .SEG(8)) dut8  (.clk(clk), .rst(rst), .bus(bus8));

  int     checks = 0;
  int     errors = 0;
  longint cyc    = 0;
  int     ordy_mode = 0;

  typedef struct {
    logic [25:0] exp;
    longint      acc;
    bit          lat;
  } entry_t;

  entry_t sbq[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: true integer arithmetic, then reduce to 24 bits / flags.
  function automatic logic [25:0] model(input logic [23:0] a, input logic [23:0] b,
                                        input logic c, input logic s);
    longint ua, ub, sa, sb, ci, u, t;
    logic   co, ov;
    ua = longint'(a);
    ub = longint'(b);
    ci = c ? 64'sd1 : 64'sd0;
    sa = a[23] ? ua - (64'sd1 <<< 24) : ua;
    sb = b[23] ? ub - (64'sd1 <<< 24) : ub;
    if (!s) begin
      u  = ua + ub + ci;
      t  = sa + sb + ci;
      co = (u >= (64'sd1 <<< 24));
    end else begin
      u  = ua - ub - ci;
      t  = sa - sb - ci;
      co = (ua >= ub + ci);
    end
    ov = (t > 64'sd8388607) || (t < -64'sd8388608);
    return {ov, co, u[23:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
    end
  endtask

  // out_ready driver: 0 = always ready, 1 = random, 2 = held low.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ordy_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = ($urandom_range(0, 3) != 0);
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops the scoreboard on every consumed result.
  initial begin
    logic        prev_stall;
    logic [25:0] prev_out;
    entry_t      e;
    prev_stall = 1'b0;
    prev_out   = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("hold_valid", 64'(bus.out_valid), 64'd1);
          chk("hold_data", 64'({bus.ovf, bus.cout, bus.S}), 64'(prev_out));
        end
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
          if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got S=0x%0h with no bundle outstanding, required none", bus.S);
          end else begin
            e = sbq.pop_front();
            chk("result{ovf,cout,S}", 64'({bus.ovf, bus.cout, bus.S}), 64'(e.exp));
            if (e.lat) chk("latency", 64'(cyc - e.acc), 64'(NS));
          end
        end
        prev_stall = (bus.out_valid === 1'b1) && (bus.out_ready === 1'b0);
        prev_out   = {bus.ovf, bus.cout, bus.S};
      end
    end
  end

  task automatic send(input logic [23:0] a, input logic [23:0] b,
                      input logic c, input logic s, input bit lat);
    int unsigned waited;
    bit          done;
    entry_t      e;
    waited       = 0;
    done         = 1'b0;
    bus.in_valid = 1'b1;
    bus.A        = a;
    bus.B        = b;
    bus.cin      = c;
    bus.sub      = s;
    while (!done) begin
      @(negedge clk);
      if (bus.in_ready) begin
        e.exp = model(a, b, c, s);
        e.acc = cyc;
        e.lat = lat;
        sbq.push_back(e);
        done = 1'b1;
      end else begin
        // Not sampled while stalled, so scramble them.
        bus.A = 24'($urandom);
        bus.B = 24'($urandom);
        waited++;
        if (waited > 100) begin
          checks++;
          errors++;
          $display("FAIL accept_timeout: in_ready stayed 0, required 1 within 100 cycles");
          done = 1'b1;
        end
      end
      @(posedge clk);
      #1;
      bus.A = a;
      bus.B = b;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_outstanding", 64'(sbq.size()), 64'd0);
  endtask

  function automatic logic [23:0] pick();
    case ($urandom_range(0, 5))
      0:       return 24'h000000;
      1:       return 24'hFFFFFF;
      2:       return 24'h800000;
      3:       return 24'h7FFFFF;
      default: return 24'($urandom);
    endcase
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    longint acc;
    int     n;
    bus.in_valid = 1'b0; bus.A = '0; bus.B = '0; bus.cin = 1'b0; bus.sub = 1'b0;
    bus32.in_valid = 1'b0; bus32.A = '0; bus32.B = '0; bus32.cin = 1'b0; bus32.sub = 1'b0;
    bus32.out_ready = 1'b1;
    bus8.in_valid = 1'b0; bus8.A = '0; bus8.B = '0; bus8.cin = 1'b0; bus8.sub = 1'b0;
    bus8.out_ready = 1'b1;

    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset_S", 64'(bus.S), 64'd0);
    chk("reset_cout", 64'(bus.cout), 64'd0);
    chk("reset_ovf", 64'(bus.ovf), 64'd0);
    chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
    idle(1);

    // Directed corner cases, continuous flow, latency checked.
    send(24'hFFFFFF, 24'h000001, 1'b0, 1'b0, 1'b1);
    send(24'h000005, 24'h000007, 1'b0, 1'b1, 1'b1);
    send(24'h800000, 24'h000001, 1'b0, 1'b1, 1'b1);
    send(24'h7FFFFF, 24'h000001, 1'b0, 1'b0, 1'b1);
    send(24'h0000FF, 24'h000000, 1'b1, 1'b0, 1'b1);
    send(24'h00FFFF, 24'h000000, 1'b1, 1'b0, 1'b1);
    send(24'h000000, 24'h000000, 1'b1, 1'b1, 1'b1);
    drain();

    // Back-to-back with a two-cycle output stall mid-stream.
    fork
      begin
        send(24'd1, 24'd1, 1'b0, 1'b0, 1'b0);
        send(24'd2, 24'd2, 1'b0, 1'b0, 1'b0);
        send(24'd3, 24'd3, 1'b0, 1'b0, 1'b0);
        send(24'd4, 24'd4, 1'b0, 1'b0, 1'b0);
      end
      begin
        n = 0;
        while (!bus.out_valid && n < 50) begin
          @(negedge clk);
          n++;
        end
        ordy_mode = 2;
        repeat (2) begin
          @(negedge clk);
          chk("stall_out_valid", 64'(bus.out_valid), 64'd1);
          chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
        end
        ordy_mode = 0;
      end
    join
    drain();

    // Reset with bundles in flight: nothing from before may emerge.
    send(24'h000055, 24'h000011, 1'b0, 1'b0, 1'b0);
    send(24'h000066, 24'h000022, 1'b0, 1'b0, 1'b0);
    idle(1);
    rst = 1'b1;
    sbq.delete();
    #1;
    chk("midreset_out_valid", 64'(bus.out_valid), 64'd0);
    chk("midreset_S", 64'(bus.S), 64'd0);
    chk("midreset_cout", 64'(bus.cout), 64'd0);
    idle(1);
    rst = 1'b0;
    idle(5);
    send(24'h000010, 24'h000020, 1'b0, 1'b0, 1'b1);
    drain();

    // Randomized traffic with random backpressure.
    ordy_mode = 1;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      send(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    end
    ordy_mode = 0;
    drain();

    // WIDTH=32: four stages.
    bus32.in_valid = 1'b1; bus32.A = 32'hFFFFFFFF; bus32.B = 32'h1; bus32.cin = 1'b0; bus32.sub = 1'b0;
    @(negedge clk);
    chk("w32_in_ready", 64'(bus32.in_ready), 64'd1);
    acc = cyc;
    @(posedge clk);
    #1;
    bus32.in_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus32.out_valid && n < 20);
    chk("w32_latency", 64'(cyc - acc), 64'd4);
    chk("w32_S", 64'(bus32.S), 64'd0);
    chk("w32_cout", 64'(bus32.cout), 64'd1);
    chk("w32_ovf", 64'(bus32.ovf), 64'd0);
    idle(1);

    // WIDTH=8: single stage, sub 0x80 - 1 overflows without borrow.
    bus8.in_valid = 1'b1; bus8.A = 8'h80; bus8.B = 8'h01; bus8.cin = 1'b0; bus8.sub = 1'b1;
    @(negedge clk);
    acc = cyc;
    @(posedge clk);
    #1;
    bus8.in_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus8.out_valid && n < 20);
    chk("w8_latency", 64'(cyc - acc), 64'd1);
    chk("w8_S", 64'(bus8.S), 64'h7F);
    chk("w8_cout", 64'(bus8.cout), 64'd1);
    chk("w8_ovf", 64'(bus8.ovf), 64'd1);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
